// File: rtl/std_cache_pkg.sv
// Shared types and constants for the std cache subsystem.
package std_cache_pkg;

  // Whole-cache flush sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    ACK
  } flush_state_e;

  // Cycles spent waiting on the dcache before a flush is abandoned.
  localparam int unsigned FLUSH_TIMEOUT_DEFAULT = 4096;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/dcache_outstanding_cnt.sv
// Saturating up/down counter of granted-but-unanswered dcache reads.
module dcache_outstanding_cnt
  import std_cache_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = clog2_min1(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Count grants up and returns down; a simultaneous pair cancels out.
  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != W'(MAX)) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

  // A grant beyond the outstanding limit or a return with nothing pending is a protocol error.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && cnt == W'(MAX)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && cnt == '0));

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Merges flush requests, drains the dcache and runs the management flush handshake.
module dcache_flush_ctrl
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_SRC          = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT         = FLUSH_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NR_SRC-1:0]    flush_req_i,
  output logic [NR_SRC-1:0]    flush_ack_o,
  input  logic                 rd_gnt_i,
  input  logic                 rd_rvalid_i,
  input  logic                 wbuffer_empty_i,
  output logic                 hold_o,
  output logic                 dcache_flush_o,
  input  logic                 dcache_flush_ack_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int unsigned OUT_W = clog2_min1(MAX_OUTSTANDING + 1);
  localparam int unsigned TO_W  = clog2_min1(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  flush_state_e       state;
  logic [NR_SRC-1:0]  mask;
  logic [NR_SRC-1:0]  ack_q;
  logic [NR_SRC-1:0]  pend;
  logic [TO_W-1:0]    to_cnt;
  logic               round_ok;
  logic [OUT_W-1:0]   out_cnt_unused;
  logic               out_zero;

  // Only the empty indication steers the sequencer; the count itself is for probing.
  dcache_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING),
    .W   (OUT_W)
  ) u_outstanding (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (rd_gnt_i),
    .dec  (rd_rvalid_i),
    .cnt  (out_cnt_unused),
    .zero (out_zero)
  );

  // A source just acked still holds its request for one cycle; keep it out of the next round.
  assign pend = flush_req_i & ~ack_q;

  // Flush sequencer: capture requesters, drain, flush with timeout, acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mask        <= '0;
      ack_q       <= '0;
      flush_ack_o <= '0;
      to_cnt      <= '0;
      round_ok    <= 1'b0;
      timeout_o   <= 1'b0;
      flush_cnt_o <= '0;
    end else begin
      ack_q       <= flush_ack_o;
      // NOTE: this default is overridden later in the block; the last non-blocking write wins.
      flush_ack_o <= '0;
      unique case (state)
        IDLE: begin
          if (|pend) begin
            mask  <= pend;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_zero && wbuffer_empty_i) begin
            to_cnt <= '0;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          if (dcache_flush_ack_i) begin
            flush_ack_o <= mask;
            round_ok    <= 1'b1;
            state       <= ACK;
          end else if (to_cnt == TO_LAST) begin
            flush_ack_o <= mask;
            round_ok    <= 1'b0;
            timeout_o   <= 1'b1;
            state       <= ACK;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ACK: begin
          if (round_ok) begin
            flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
          end
          mask  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are pure state decodes, so no input reaches an output combinationally.
  assign hold_o         = (state != IDLE);
  assign busy_o         = (state != IDLE);
  assign dcache_flush_o = (state == FLUSH);

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench for dcache_flush_ctrl: directed scenarios plus randomized rounds
// predicted from cycle arithmetic (drain end, ack delay versus timeout window).
module tb_dcache_flush_ctrl;

  localparam int NR_SRC = 3;
  localparam int MAX_OUT = 4;
  localparam int TO = 16;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR_SRC-1:0] flush_req;
  logic [NR_SRC-1:0] flush_ack;
  logic              rd_gnt;
  logic              rd_rvalid;
  logic              wbuf_empty;
  logic              hold;
  logic              dflush;
  logic              dflush_ack;
  logic              busy;
  logic              timeout;
  logic [CW-1:0]     flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_flush_ctrl #(
    .NR_SRC          (NR_SRC),
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT         (TO),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_req_i        (flush_req),
    .flush_ack_o        (flush_ack),
    .rd_gnt_i           (rd_gnt),
    .rd_rvalid_i        (rd_rvalid),
    .wbuffer_empty_i    (wbuf_empty),
    .hold_o             (hold),
    .dcache_flush_o     (dflush),
    .dcache_flush_ack_i (dflush_ack),
    .busy_o             (busy),
    .timeout_o          (timeout),
    .flush_cnt_o        (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int c, input logic busy_e,
                            input logic fl_e, input logic [NR_SRC-1:0] ack_e);
    check($sformatf("%s_hold_c%0d", tag, c), {31'd0, hold}, {31'd0, busy_e});
    check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, {31'd0, busy_e});
    check($sformatf("%s_dflush_c%0d", tag, c), {31'd0, dflush}, {31'd0, fl_e});
    check($sformatf("%s_ack_c%0d", tag, c), 32'(flush_ack), 32'(ack_e));
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_req = '0;
    rd_gnt = 1'b0;
    rd_rvalid = 1'b0;
    wbuf_empty = 1'b1;
    dflush_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int hi;
    int n, w, d, t, f, a, e, last;
    int rv[MAX_OUT];
    logic [NR_SRC-1:0] msk;
    int exp_cnt;
    logic exp_to;

    // Reset state.
    do_reset();
    check_outs("reset", 0, 1'b0, 1'b0, '0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_cnt", 32'(flush_cnt), 32'd0);

    // Single source, drained cache, ack at cycle 5.
    flush_req = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      step();
      dflush_ack = (c == 5);
      if (c == 8) flush_req = '0;
      check_outs("single", c, c <= 6, c >= 2 && c <= 5, (c == 6) ? 3'b001 : 3'b000);
    end
    check("single_cnt", 32'(flush_cnt), 32'd1);
    check("single_timeout", {31'd0, timeout}, 32'd0);

    // Drain wait: two reads outstanding, write buffer busy until cycle 8.
    do_reset();
    rd_gnt = 1'b1;
    step();
    step();
    rd_gnt = 1'b0;
    flush_req = 3'b010;
    wbuf_empty = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      rd_rvalid = (c == 4 || c == 6);
      wbuf_empty = (c >= 8);
      dflush_ack = (c == 9);
      if (c == 11) flush_req = '0;
      check_outs("drain", c, c <= 10, c == 9, (c == 10) ? 3'b010 : 3'b000);
    end
    check("drain_cnt", 32'(flush_cnt), 32'd1);

    // Merge: sources 0 and 2 together, source 1 arrives during FLUSH.
    do_reset();
    flush_req = 3'b101;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 3) flush_req[1] = 1'b1;
      dflush_ack = (c == 4 || c == 9);
      if (c == 7) begin
        flush_req[0] = 1'b0;
        flush_req[2] = 1'b0;
      end
      if (c == 12) flush_req[1] = 1'b0;
      check_outs("merge", c, (c <= 5) || (c >= 7 && c <= 10),
                 (c >= 2 && c <= 4) || (c >= 8 && c <= 9),
                 (c == 5) ? 3'b101 : ((c == 10) ? 3'b010 : 3'b000));
    end
    check("merge_cnt", 32'(flush_cnt), 32'd2);

    // Timeout: no ack ever arrives.
    do_reset();
    flush_req = 3'b001;
    hi = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 20) flush_req = '0;
      hi += int'(dflush);
      check($sformatf("to_ack_c%0d", c), 32'(flush_ack), (c == 18) ? 32'd1 : 32'd0);
      check($sformatf("to_sticky_c%0d", c), {31'd0, timeout}, (c >= 18) ? 32'd1 : 32'd0);
    end
    check("to_flush_cycles", 32'(hi), 32'(TO));
    check("to_cnt", 32'(flush_cnt), 32'd0);

    // Ack arrives on the last FLUSH cycle: ack wins over timeout.
    do_reset();
    flush_req = 3'b001;
    for (int c = 1; c <= 21; c++) begin
      step();
      dflush_ack = (c == 17);
      if (c == 20) flush_req = '0;
      check_outs("coll", c, c <= 18, c >= 2 && c <= 17, (c == 18) ? 3'b001 : 3'b000);
      check($sformatf("coll_timeout_c%0d", c), {31'd0, timeout}, 32'd0);
    end
    check("coll_cnt", 32'(flush_cnt), 32'd1);

    // Reset pulse in the middle of FLUSH, then stray dcache acks while idle.
    flush_req = 3'b001;
    step();
    step();
    step();
    check("rst_pre_dflush", {31'd0, dflush}, 32'd1);
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 0, 1'b0, 1'b0, '0);
    check("rst_mid_timeout", {31'd0, timeout}, 32'd0);
    check("rst_mid_cnt", 32'(flush_cnt), 32'd0);
    flush_req = '0;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      dflush_ack = 1'b1;
      check_outs("stray", c, 1'b0, 1'b0, '0);
      check($sformatf("stray_cnt_c%0d", c), 32'(flush_cnt), 32'd0);
    end
    dflush_ack = 1'b0;

    // Randomized rounds: predict drain end and ack/timeout outcome from cycle arithmetic.
    do_reset();
    exp_cnt = 0;
    exp_to = 1'b0;
    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(0, MAX_OUT));
      w = int'($urandom_range(0, 10));
      d = int'($urandom_range(1, 20));
      msk = NR_SRC'($urandom_range(1, (1 << NR_SRC) - 1));
      for (int g = 0; g < n; g++) begin
        rd_gnt = 1'b1;
        step();
      end
      rd_gnt = 1'b0;
      last = 0;
      for (int k = 0; k < MAX_OUT; k++) rv[k] = -1;
      for (int k = 0; k < n; k++) begin
        last += int'($urandom_range(1, 3));
        rv[k] = last;
      end
      // First DRAIN cycle is 1; it ends once reads are back and the write buffer is empty.
      t = 1;
      if (n > 0 && last + 1 > t) t = last + 1;
      if (w > t) t = w;
      f = t + 1;
      a = f + ((d < TO) ? d : TO);
      e = (a + 2 > f + d) ? a + 2 : f + d;
      flush_req = msk;
      wbuf_empty = (w <= 0);
      for (int c = 1; c <= e; c++) begin
        step();
        rd_rvalid = 1'b0;
        for (int k = 0; k < n; k++) if (rv[k] == c) rd_rvalid = 1'b1;
        wbuf_empty = (c >= w);
        dflush_ack = (c == f + d - 1);
        if (c == a + 2) flush_req = '0;
        check_outs($sformatf("rnd%0d", r), c, c <= a, c >= f && c < a,
                   (c == a) ? msk : '0);
      end
      rd_rvalid = 1'b0;
      dflush_ack = 1'b0;
      wbuf_empty = 1'b1;
      if (d <= TO) exp_cnt++;
      else exp_to = 1'b1;
      check($sformatf("rnd%0d_cnt", r), 32'(flush_cnt), 32'(exp_cnt));
      check($sformatf("rnd%0d_timeout", r), {31'd0, timeout}, {31'd0, exp_to});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
